// File: rtl/unified_memory_arbiter_pkg.sv
// mem_arb_pkg: shared state and ownership types for the unified memory arbiter.
package mem_arb_pkg;
    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/unified_memory_arbiter_if.sv
// unified_memory_arbiter_if: fetch, data and physical-memory signals around the arbiter.
interface unified_memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_valid;
    logic                  stall_if;
    logic                  stall_mem;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: shares one single-port memory between fetch and data stages,
// tracking the fixed latency and stalling the pipeline until each owner's access returns.
module unified_memory_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int DM_BURST_MAX = 4
) (
    input logic clk,
    input logic reset,
    unified_memory_arbiter_if.slave bus
);
    localparam int LW = $clog2(MEM_LATENCY) + 1;
    localparam int BW = $clog2(DM_BURST_MAX + 1);
    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          drop_q, drop_d;
    logic          if_ok, burst_full, grant_if, grant_dm, done, if_hit, dm_hit;
    // Outputs are gated by reset so nothing escapes while the pipeline is held in reset.
    always_comb begin
        if_ok      = bus.if_req && !bus.if_flush;
        burst_full = burst_q == BW'(DM_BURST_MAX);
        grant_if   = reset && state_q == IDLE && if_ok && (!bus.dm_req || burst_full);
        grant_dm   = reset && state_q == IDLE && bus.dm_req && !grant_if;
        done       = reset && state_q == WAIT && lat_q == '0;
        if_hit     = done && owner_q == OWN_IF && !drop_q && !bus.if_flush;
        dm_hit     = done && owner_q == OWN_DM;
        state_d    = (grant_if || grant_dm) ? WAIT : done ? IDLE : state_q;
        owner_d    = grant_if ? OWN_IF : grant_dm ? OWN_DM : done ? OWN_NONE : owner_q;
        lat_d      = (grant_if || grant_dm) ? LW'(MEM_LATENCY - 1) :
                     (state_q == WAIT && lat_q != '0) ? lat_q - LW'(1) : lat_q;
        burst_d    = grant_if ? '0 :
                     grant_dm ? (bus.if_req ? (burst_full ? burst_q : burst_q + BW'(1)) : '0) :
                     burst_q;
        drop_d     = state_q == WAIT && !done && (drop_q || (owner_q == OWN_IF && bus.if_flush));
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            lat_q   <= '0;
            burst_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            burst_q <= burst_d;
            drop_q  <= drop_d;
        end
    end
    assign bus.mem_en    = grant_if || grant_dm;
    assign bus.mem_we    = grant_dm && bus.dm_we;
    assign bus.mem_addr  = grant_dm ? bus.dm_addr : grant_if ? bus.if_addr : '0;
    assign bus.mem_wdata = grant_dm ? bus.dm_wdata : '0;
    assign bus.if_valid  = if_hit;
    assign bus.if_rdata  = if_hit ? bus.mem_rdata : '0;
    assign bus.dm_valid  = dm_hit;
    assign bus.dm_rdata  = dm_hit ? bus.mem_rdata : '0;
    assign bus.stall_if  = reset && bus.if_req && !if_hit && !bus.if_flush;
    assign bus.stall_mem = reset && bus.dm_req && !dm_hit;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// tb_unified_memory_arbiter: directed scenarios with a latency-2 memory model and
// per-requester scoreboards of expected read data.
module tb_unified_memory_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [31:0] mem [1024];
    logic [31:0] p1, p2;
    logic [31:0] if_q[$];
    logic [32:0] dm_q[$];
    int          g_cyc[$];
    logic [31:0] g_addr[$];
    int          ifv[$];
    int          dmv[$];
    int          t;
    unified_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
    unified_memory_arbiter #(.MEM_LATENCY(2), .DM_BURST_MAX(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Two-stage read pipe gives data exactly two cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
        p2 <= p1;
        p1 <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[11:2]] : 32'hBAD0BAD0;
        if (!reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 + i * 32'h0101_0013;
            mem[64] <= 32'h00A00093;
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = p2;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask
    function automatic logic [31:0] ctl();
        return {26'b0, bus.if_valid, bus.dm_valid, bus.stall_if, bus.stall_mem, bus.mem_en, bus.mem_we};
    endfunction
    function automatic logic [31:0] dbus();
        return bus.if_rdata | bus.dm_rdata | bus.mem_addr | bus.mem_wdata;
    endfunction
    always @(negedge clk) if (reset) begin
        if (bus.mem_en) begin
            g_cyc.push_back(cyc);
            g_addr.push_back(bus.mem_addr);
        end
        if (bus.if_valid) begin
            ifv.push_back(cyc);
            chk("if_q_nonempty", 32'(if_q.size() != 0), 1);
            if (if_q.size() != 0) chk("if_rdata", bus.if_rdata, if_q.pop_front());
        end
        if (bus.dm_valid) begin
            dmv.push_back(cyc);
            chk("dm_q_nonempty", 32'(dm_q.size() != 0), 1);
            if (dm_q.size() != 0) begin
                logic [32:0] e;
                e = dm_q.pop_front();
                if (!e[32]) chk("dm_rdata", bus.dm_rdata, e[31:0]);
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_logs();
        g_cyc.delete();
        g_addr.delete();
        ifv.delete();
        dmv.delete();
    endtask
    task automatic if_fetch(input logic [31:0] a);
        int n;
        bus.if_addr = a;
        bus.if_req = 1'b1;
        if_q.push_back(mem[a[11:2]]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.if_valid && n < 64);
        chk("if_done", 32'(bus.if_valid), 1);
        step();
        bus.if_req = 1'b0;
    endtask
    task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        bus.dm_we = we;
        bus.dm_addr = a;
        bus.dm_wdata = d;
        bus.dm_req = 1'b1;
        dm_q.push_back({we, we ? 32'h0 : mem[a[11:2]]});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.dm_valid && n < 64);
        chk("dm_done", 32'(bus.dm_valid), 1);
        step();
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end
    initial begin
        logic [31:0] ea [6];
        ea = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h300, 32'h4010};
        reset = 1'b0;
        bus.if_req = 1'b1;
        bus.if_addr = 32'h44;
        bus.if_flush = 1'b0;
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h88;
        bus.dm_wdata = 32'h1234;
        step();
        step();
        @(negedge clk);
        chk("rst_ctl", ctl(), 0);
        chk("rst_bus", dbus(), 0);
        step();
        reset = 1'b1;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        step();
        // single fetch
        bus.if_addr = 32'h100;
        bus.if_req = 1'b1;
        if_q.push_back(32'h00A00093);
        @(negedge clk);
        chk("t1_en", 32'(bus.mem_en), 1);
        chk("t1_addr", bus.mem_addr, 32'h100);
        chk("t1_stall0", 32'(bus.stall_if), 1);
        @(negedge clk);
        chk("t1_stall1", 32'(bus.stall_if), 1);
        chk("t1_early", 32'(bus.if_valid), 0);
        @(negedge clk);
        chk("t1_valid", 32'(bus.if_valid), 1);
        chk("t1_stall2", 32'(bus.stall_if), 0);
        step();
        bus.if_req = 1'b0;
        step();
        // simultaneous fetch and load
        clear_logs();
        t = cyc;
        fork
            if_fetch(32'h104);
            dm_access(1'b0, 32'h2000, 32'h0);
        join
        chk("t2_g0_cyc", 32'(g_cyc[0]), 32'(t));
        chk("t2_g0_addr", g_addr[0], 32'h2000);
        chk("t2_dmv", 32'(dmv[0]), 32'(t + 2));
        chk("t2_g1_cyc", 32'(g_cyc[1]), 32'(t + 3));
        chk("t2_g1_addr", g_addr[1], 32'h104);
        chk("t2_ifv", 32'(ifv[0]), 32'(t + 5));
        step();
        // data burst starving a pending fetch
        clear_logs();
        t = cyc;
        fork
            for (int i = 0; i < 5; i++) dm_access(1'b0, 32'h4000 + 32'(i * 4), 32'h0);
            if_fetch(32'h300);
        join
        chk("t3_count", 32'(g_addr.size()), 6);
        chk("t3_first", 32'(g_cyc[0]), 32'(t));
        for (int i = 0; i < 6; i++) chk("t3_order", g_addr[i], ea[i]);
        for (int i = 0; i < 5; i++) chk("t3_gap", 32'(g_cyc[i+1] - g_cyc[i]), 3);
        step();
        // store then read back
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h3000;
        bus.dm_wdata = 32'hDEADBEEF;
        bus.dm_req = 1'b1;
        dm_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        chk("t4_en", 32'(bus.mem_en), 1);
        chk("t4_we", 32'(bus.mem_we), 1);
        chk("t4_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("t4_addr", bus.mem_addr, 32'h3000);
        chk("t4_stall0", 32'(bus.stall_mem), 1);
        @(negedge clk);
        chk("t4_stall1", 32'(bus.stall_mem), 1);
        chk("t4_idle_en", 32'(bus.mem_en), 0);
        @(negedge clk);
        chk("t4_valid", 32'(bus.dm_valid), 1);
        chk("t4_stall2", 32'(bus.stall_mem), 0);
        step();
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        dm_access(1'b0, 32'h3000, 32'h0);
        step();
        // flush during an owned fetch
        bus.if_addr = 32'h180;
        bus.if_req = 1'b1;
        @(negedge clk);
        chk("t5_grant", 32'(bus.mem_en), 1);
        step();
        bus.if_flush = 1'b1;
        @(negedge clk);
        chk("t5_stall_flush", 32'(bus.stall_if), 0);
        step();
        bus.if_flush = 1'b0;
        bus.if_addr = 32'h200;
        if_q.push_back(mem[128]);
        @(negedge clk);
        chk("t5_dropped", 32'(bus.if_valid), 0);
        chk("t5_busy", 32'(bus.mem_en), 0);
        step();
        @(negedge clk);
        chk("t5_regrant", 32'(bus.mem_en), 1);
        chk("t5_regrant_addr", bus.mem_addr, 32'h200);
        step();
        step();
        @(negedge clk);
        chk("t5_valid", 32'(bus.if_valid), 1);
        step();
        bus.if_req = 1'b0;
        step();
        // reset in the middle of a data access
        bus.dm_addr = 32'h5000;
        bus.dm_req = 1'b1;
        @(negedge clk);
        chk("t6_grant", 32'(bus.mem_en), 1);
        step();
        reset = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        chk("t6_in_rst", ctl(), 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t6_ctl", ctl(), 0);
        chk("t6_bus", dbus(), 0);
        step();
        @(negedge clk);
        chk("t6_no_valid", 32'(bus.dm_valid), 0);
        chk("if_q_left", 32'(if_q.size()), 0);
        chk("dm_q_left", 32'(dm_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
